// File: rtl/bimodal_wr_sched.sv
// Write-port scheduler for the bimodal predictor table: sweeps the table after reset/clear,
// then merges saturating counter updates into bytes and drains them through a small FIFO.
module bimodal_wr_sched #(
  parameter int          IDX_W      = 8,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] INIT_WORD  = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr_req,
  input  logic                          stall,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [IDX_W-1:0]              upd_index,
  input  logic [3:0]                    upd_slot,
  input  logic [1:0]                    upd_ctr,
  input  logic                          upd_dir,
  input  logic [7:0]                    upd_byte,
  output logic [IDX_W-1:0]              mem_wraddress,
  output logic [31:0]                   mem_data,
  output logic [3:0]                    mem_byteena,
  output logic                          mem_wren,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   merge_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic [7:0]       data;
  } entry_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] sweep_idx;
  logic             sweep_last;

  entry_t           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [PW:0]      count;
  logic             full, empty, push, pop;
  entry_t           head;

  entry_t           last_entry, new_entry;
  logic             last_valid, last_hit;
  logic [1:0]       new_ctr;
  logic [7:0]       base_byte, merged_byte;

  assign sweep_last = &sweep_idx;
  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign head       = fifo_mem[rd_ptr];
  assign push       = upd_valid & upd_ready;
  assign pop        = (state == ST_RUN) & ~empty & ~stall;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
  always_comb begin
    state_nxt = state;
    if (clr_req)                                state_nxt = ST_INIT;
    else if (state == ST_INIT && sweep_last)    state_nxt = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset)                             sweep_idx <= '0;
    else if (clr_req || state == ST_RUN)    sweep_idx <= '0;
    else                                    sweep_idx <= sweep_idx + 1'b1;
  end

  // A back-to-back update to the same row/lane must build on the byte still in flight.
  always_comb begin
    last_hit  = last_valid && (last_entry.idx == upd_index) && (last_entry.lane == upd_slot[3:2]);
    base_byte = last_hit ? last_entry.data : upd_byte;
    if (upd_dir) new_ctr = (upd_ctr == 2'b11) ? 2'b11 : upd_ctr + 2'd1;
    else         new_ctr = (upd_ctr == 2'b00) ? 2'b00 : upd_ctr - 2'd1;
    merged_byte = base_byte;
    merged_byte[{upd_slot[1:0], 1'b0} +: 2] = new_ctr;
    new_entry = '{idx: upd_index, lane: upd_slot[3:2], data: merged_byte};
  end

  always_ff @(posedge clk) begin
    if (!reset || clr_req) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // NOTE: FIFO storage is deliberately not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_valid  <= 1'b0;
      last_entry  <= '0;
      merge_count <= '0;
    end else if (clr_req) begin
      last_valid  <= 1'b0;
    end else if (push) begin
      last_valid  <= 1'b1;
      last_entry  <= new_entry;
      if (last_hit) merge_count <= merge_count + 16'd1;
    end
  end

  always_comb begin
    upd_ready  = reset && (state == ST_RUN) && !full && !clr_req;
    init_done  = (state == ST_RUN);
    fifo_count = count;
    if (state == ST_INIT) begin
      mem_wren      = reset;
      mem_wraddress = sweep_idx;
      mem_data      = INIT_WORD;
      mem_byteena   = 4'hF;
    end else begin
      mem_wren      = ~empty & ~stall;
      mem_wraddress = head.idx;
      mem_data      = 32'(head.data) << {head.lane, 3'b000};
      mem_byteena   = 4'b0001 << head.lane;
    end
  end

endmodule

// File: tb/tb_bimodal_wr_sched.sv
// Self-checking bench for bimodal_wr_sched: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model.
module tb_bimodal_wr_sched;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, clr_req, stall, upd_valid;
  logic        upd_ready;
  logic [7:0]  upd_index;
  logic [3:0]  upd_slot;
  logic [1:0]  upd_ctr;
  logic        upd_dir;
  logic [7:0]  upd_byte;
  logic [7:0]  mem_wraddress;
  logic [31:0] mem_data;
  logic [3:0]  mem_byteena;
  logic        mem_wren, init_done;
  logic [2:0]  fifo_count;
  logic [15:0] merge_count;

  int checks   = 0;
  int failures = 0;

  bimodal_wr_sched #(.IDX_W(8), .FIFO_DEPTH(DEPTH), .INIT_WORD(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .stall(stall),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index),
    .upd_slot(upd_slot), .upd_ctr(upd_ctr), .upd_dir(upd_dir), .upd_byte(upd_byte),
    .mem_wraddress(mem_wraddress), .mem_data(mem_data), .mem_byteena(mem_byteena),
    .mem_wren(mem_wren), .init_done(init_done), .fifo_count(fifo_count),
    .merge_count(merge_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: pending writes as a queue of {row, lane, byte}.
  typedef struct {
    logic [7:0] idx;
    logic [1:0] lane;
    logic [7:0] b;
  } ent_t;

  ent_t q[$];
  ent_t l_e;
  bit   l_valid = 0;
  bit   m_init  = 1;
  bit   m_known = 0;
  int   m_sweep = 0;
  int   m_merge = 0;

  always @(posedge clk) begin : model
    ent_t e;
    int   nc, sh, bi;
    bit   acc, pp, hit;
    if (!reset) begin
      m_init = 1; m_sweep = 0; q.delete(); l_valid = 0; m_merge = 0;
    end else begin
      acc = upd_valid && !m_init && q.size() < DEPTH && !clr_req;
      pp  = !m_init && q.size() > 0 && !stall;
      if (clr_req) begin
        q.delete(); l_valid = 0; m_init = 1; m_sweep = 0;
      end else if (m_init) begin
        if (m_sweep == 255) begin m_init = 0; m_sweep = 0; end
        else m_sweep++;
      end else begin
        if (pp) void'(q.pop_front());
        if (acc) begin
          nc  = upd_dir ? ((int'(upd_ctr) == 3) ? 3 : int'(upd_ctr) + 1)
                        : ((int'(upd_ctr) == 0) ? 0 : int'(upd_ctr) - 1);
          hit = l_valid && l_e.idx == upd_index && l_e.lane == upd_slot[3:2];
          bi  = hit ? int'(l_e.b) : int'(upd_byte);
          sh  = 2 * int'(upd_slot[1:0]);
          bi  = (bi & ~(3 << sh)) | (nc << sh);
          e.idx = upd_index; e.lane = upd_slot[3:2]; e.b = bi[7:0];
          q.push_back(e);
          l_e = e; l_valid = 1;
          if (hit) m_merge++;
        end
      end
    end
    m_known = 1;
  end

  always begin : compare
    ent_t e;
    bit   w;
    @(negedge clk); #3;
    if (m_known) begin
      check("init_done", {31'b0, init_done}, {31'b0, !m_init});
      check("upd_ready", {31'b0, upd_ready},
            {31'b0, reset && !m_init && q.size() < DEPTH && !clr_req});
      check("fifo_count", {29'b0, fifo_count}, q.size());
      check("merge_count", {16'b0, merge_count}, m_merge & 32'hFFFF);
      if (m_init) begin
        check("mem_wren_init", {31'b0, mem_wren}, {31'b0, reset});
        if (reset) begin
          check("sweep_addr", {24'b0, mem_wraddress}, m_sweep);
          check("sweep_data", mem_data, 32'h0);
          check("sweep_be", {28'b0, mem_byteena}, 32'hF);
        end
      end else begin
        w = q.size() > 0 && !stall;
        check("mem_wren", {31'b0, mem_wren}, {31'b0, w});
        if (w) begin
          e = q[0];
          check("wr_addr", {24'b0, mem_wraddress}, {24'b0, e.idx});
          check("wr_data", mem_data, 32'(e.b) << (8 * int'(e.lane)));
          check("wr_be", {28'b0, mem_byteena}, 32'(1) << e.lane);
        end
      end
    end
  end

  task automatic nx();
    @(negedge clk);
    upd_valid = 1'b0;
    clr_req   = 1'b0;
  endtask

  task automatic up(input logic [7:0] idx, input logic [3:0] slot, input logic [1:0] ctr,
                    input logic dir, input logic [7:0] b);
    upd_valid = 1'b1; upd_index = idx; upd_slot = slot;
    upd_ctr = ctr; upd_dir = dir; upd_byte = b;
  endtask

  // Called at the first sweep cycle; counts in-order row writes until init_done rises.
  task automatic run_sweep(input string name);
    int rows;
    bit done;
    rows = 0; done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (init_done) done = 1;
      else begin
        if (mem_wren && mem_wraddress == rows[7:0]) rows++;
        nx(); #3;
      end
    end
    check({name, "_rows"}, rows, 256);
    check({name, "_done"}, {31'b0, done}, 1);
  endtask

  task automatic seek_row(input int row);
    bit found;
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      nx(); #3;
      if (mem_wren && mem_wraddress == row[7:0]) found = 1;
    end
    check("seek_row", {31'b0, found}, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 0; clr_req = 0; stall = 0; upd_valid = 0;
    upd_index = 0; upd_slot = 0; upd_ctr = 0; upd_dir = 0; upd_byte = 0;

    // Reset held three edges, then the sweep.
    nx(); nx(); #3;
    check("rst_wren", {31'b0, mem_wren}, 0);
    check("rst_ready", {31'b0, upd_ready}, 0);
    nx(); reset = 1; #3;
    check("first_row", {24'b0, mem_wraddress}, 0);
    run_sweep("init");
    check("ready_after_init", {31'b0, upd_ready}, 1);

    // Single update.
    nx(); up(8'h12, 4'b1001, 2'b01, 1'b1, 8'h00);
    nx(); #3;
    check("single_wren", {31'b0, mem_wren}, 1);
    check("single_addr", {24'b0, mem_wraddress}, 32'h12);
    check("single_be", {28'b0, mem_byteena}, 32'h4);
    check("single_data", mem_data, 32'h0008_0000);
    nx(); #3;
    check("single_drained", {29'b0, fifo_count}, 0);

    // Saturation and merge with the forwarded byte.
    nx(); up(8'h05, 4'b0000, 2'b11, 1'b1, 8'h03);
    nx(); up(8'h05, 4'b0001, 2'b11, 1'b1, 8'h03); #3;
    check("sat_data", mem_data, 32'h0000_0003);
    nx(); #3;
    check("merge_data", mem_data, 32'h0000_000F);
    check("merge_cnt", {16'b0, merge_count}, 1);

    // Full FIFO under stall.
    nx(); stall = 1;
    for (int i = 0; i < 4; i++) begin
      up(8'h20 + 8'(i), 4'(i * 4), 2'b00, 1'b1, 8'h00);
      nx();
    end
    up(8'h77, 4'b0000, 2'b01, 1'b1, 8'h00); #3;
    check("full_ready", {31'b0, upd_ready}, 0);
    check("full_count", {29'b0, fifo_count}, 4);
    nx(); #3;
    check("full_no_push", {29'b0, fifo_count}, 4);
    nx(); stall = 0; #3;
    check("release_wren", {31'b0, mem_wren}, 1);
    nx(); #3;
    check("ready_after_pop", {31'b0, upd_ready}, 1);
    repeat (4) nx();

    // Push and pop together at occupancy 2.
    nx(); stall = 1; up(8'h50, 4'b0100, 2'b01, 1'b0, 8'hAA);
    nx(); up(8'h51, 4'b1000, 2'b10, 1'b1, 8'h55);
    nx(); stall = 0;
    for (int i = 0; i < 5; i++) begin
      up(8'h60 + 8'(i), 4'(i), 2'(i), 1'(i), 8'h3C);
      #3;
      check("pp_count", {29'b0, fifo_count}, 2);
      check("pp_wren", {31'b0, mem_wren}, 1);
      nx();
    end
    repeat (4) nx();

    // clr_req in RUN with three pending entries.
    nx(); stall = 1; up(8'h30, 4'b0000, 2'b01, 1'b1, 8'hFF);
    nx(); up(8'h31, 4'b0100, 2'b01, 1'b1, 8'hFF);
    nx(); up(8'h32, 4'b1000, 2'b01, 1'b1, 8'hFF);
    nx(); clr_req = 1; up(8'h33, 4'b1100, 2'b01, 1'b1, 8'hFF); #3;
    check("clr_ready", {31'b0, upd_ready}, 0);
    check("clr_pending", {29'b0, fifo_count}, 3);
    nx(); stall = 0; #3;
    check("clr_flushed", {29'b0, fifo_count}, 0);
    check("clr_init_done", {31'b0, init_done}, 0);
    run_sweep("clr");

    // clr_req during INIT restarts at row 0, then reset mid-sweep at row 100.
    nx(); clr_req = 1;
    seek_row(50);
    nx(); clr_req = 1;
    nx(); #3;
    check("clr_init_restart", {24'b0, mem_wraddress}, 0);
    seek_row(100);
    nx(); reset = 0;
    nx(); nx(); reset = 1; #3;
    check("rst_mid_addr", {24'b0, mem_wraddress}, 0);
    run_sweep("rst_mid");

    // Random traffic on a few rows so merges occur.
    for (int k = 0; k < 800; k++) begin
      nx();
      stall     = ($urandom_range(3) == 0);
      clr_req   = ($urandom_range(199) == 0);
      upd_valid = 1'($urandom_range(1));
      upd_index = 8'h40 + 8'($urandom_range(3));
      upd_slot  = 4'($urandom);
      upd_ctr   = 2'($urandom);
      upd_dir   = 1'($urandom);
      upd_byte  = 8'($urandom);
    end
    nx(); stall = 0;
    repeat (10) nx();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
